// File: rtl/sweeper_pkg.sv
// sweeper_pkg
//   Shared types and constants for the truth-table sweeper.
//   - sweep_state_t : sweep controller state encoding
//   - Q6_TRUTH      : truth table of Y = A'BC' + AB'C (minterms 2 and 5),
//                     bit i = expected Y for input vector i
//   - DEFAULT_SETTLE: default settle time in clock cycles
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

  localparam logic [7:0] Q6_TRUTH       = 8'b0010_0100;
  localparam int         DEFAULT_SETTLE = 2;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   4-bit settle counter. Clears to zero on clear, otherwise counts up while
//   en is high. tc flags that the counter has reached SETTLE_CYCLES-1, i.e.
//   the current SETTLE cycle is the last one before sampling.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   clear in  synchronous clear (wins over en)
//   en    in  count enable
//   tc    out terminal count flag (count == SETTLE_CYCLES-1)
module settle_timer
  import sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] TC_VALUE = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 4'd0;
    end else if (clear) begin
      count_reg <= 4'd0;
    end else if (en) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  assign tc = (count_reg == TC_VALUE);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Steps a small combinational DUT through every input vector in binary
//   order, waits SETTLE_CYCLES after each step, samples the DUT output and
//   compares it against the EXPECTED truth table. Reports mismatch count,
//   first failing row and pass/fail. All outputs are registered.
// Ports:
//   CLK            in   clock, rising edge
//   RESET          in   asynchronous active-high reset
//   start          in   sweep request, honoured only in IDLE
//   Y_in           in   DUT output
//   vec            out  DUT input vector (vec[N_IN-1] = A ... vec[0] = C)
//   busy           out  sweep in progress
//   done           out  one-cycle end-of-sweep pulse
//   pass           out  last completed sweep had no mismatches
//   err_count      out  mismatching rows in current/last sweep
//   fail_valid     out  at least one mismatch recorded
//   first_fail_idx out  row index of the first mismatch
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int                N_IN          = 3,
  parameter int                SETTLE_CYCLES = DEFAULT_SETTLE,
  parameter logic [2**N_IN-1:0] EXPECTED     = Q6_TRUTH
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic            Y_in,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam logic [N_IN-1:0] LAST_ROW = '1;
  localparam logic [N_IN-1:0] ONE_ROW  = 1;
  localparam logic [N_IN:0]   ONE_ERR  = 1;

  sweep_state_t state_reg;
  logic         settle_clear;
  logic         settle_en;
  logic         settle_tc;

  // The timer restarts whenever a fresh row is driven: on sweep acceptance
  // and on leaving SAMPLE for the next row.
  assign settle_clear = ((state_reg == IDLE) && start) || (state_reg == SAMPLE);
  assign settle_en    = (state_reg == SETTLE);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (CLK),
    .rst  (RESET),
    .clear(settle_clear),
    .en   (settle_en),
    .tc   (settle_tc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // pass keeps the previous sweep's verdict until the next DONE.
          if (start) begin
            state_reg      <= SETTLE;
            vec            <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            busy           <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_tc) begin
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (Y_in != EXPECTED[vec]) begin
            err_count <= err_count + ONE_ERR;
            if (!fail_valid) begin
              first_fail_idx <= vec;
              fail_valid     <= 1'b1;
            end
          end
          // vec holds the last row through DONE instead of wrapping.
          if (vec == LAST_ROW) begin
            state_reg <= DONE;
          end else begin
            vec       <= vec + ONE_ROW;
            state_reg <= SETTLE;
          end
        end
        DONE: begin
          // err_count already includes the last row, updated in SAMPLE.
          done      <= 1'b1;
          busy      <= 1'b0;
          pass      <= (err_count == '0);
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic       clk;
  logic       RESET;
  logic       start0;
  logic       start1;
  logic       y0;
  logic       y1;
  logic [2:0] vec0;
  logic [2:0] vec1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       pass0, pass1;
  logic [3:0] err0, err1;
  logic       fv0, fv1;
  logic [2:0] ffi0, ffi1;

  int checks   = 0;
  int failures = 0;
  int y_mode   = 0;
  int prev_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  truth_table_sweeper #(
    .N_IN(3), .SETTLE_CYCLES(2), .EXPECTED(8'b0010_0100)
  ) dut0 (
    .CLK(clk), .RESET(RESET), .start(start0), .Y_in(y0), .vec(vec0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_idx(ffi0)
  );

  truth_table_sweeper #(
    .N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'b0010_0100)
  ) dut1 (
    .CLK(clk), .RESET(RESET), .start(start1), .Y_in(y1), .vec(vec1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  // DUT stand-in: Y = A'BC' + AB'C (true for rows 2 and 5), plus faulty variants.
  function automatic logic model_y(input int mode, input logic [2:0] v);
    logic good;
    good = (v == 3'd2) || (v == 3'd5);
    case (mode)
      0: return good;
      1: return 1'b0;
      2: return !good;
      3: return 1'b1;
      4: return good ^ (v == 3'd7);
      default: return good;
    endcase
  endfunction

  always_comb begin
    y0 = model_y(y_mode, vec0);
    y1 = model_y(0, vec1);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One sweep on dut0; extra start pulses land at edges extra_a/extra_b.
  // Edge 0 is the edge that accepts start.
  task automatic run_sweep(input int mode, input int extra_a, input int extra_b);
    int dones;
    int exp_vec;
    y_mode = mode;
    dones  = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = ((k + 1) == extra_a) || ((k + 1) == extra_b);
      if (k <= 24) begin
        exp_vec = (k / 3 > 7) ? 7 : k / 3;
        check($sformatf("vec@%0d", k), int'(vec0), exp_vec);
      end
      check($sformatf("busy@%0d", k), int'(busy0), (k <= 24) ? 1 : 0);
      check($sformatf("done@%0d", k), int'(done0), (k == 25) ? 1 : 0);
      if (k == 10) check("pass_hold", int'(pass0), prev_pass);
      if (done0) dones++;
    end
    check("done_count", dones, 1);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_first;
    int    exp_fv;
    int    exp_pass;
  } sweep_vec_t;

  sweep_vec_t tbl[5];

  task automatic check_result(input sweep_vec_t t);
    check({t.name, "_err"},   int'(err0), t.exp_err);
    check({t.name, "_first"}, int'(ffi0), t.exp_first);
    check({t.name, "_fv"},    int'(fv0),  t.exp_fv);
    check({t.name, "_pass"},  int'(pass0), t.exp_pass);
    $display("sweep %s: err=%0d first=%0d fv=%0d pass=%0d",
             t.name, err0, ffi0, fv0, pass0);
  endtask

  initial begin
    tbl[0] = '{"correct",  0, 0, 0, 0, 1};
    tbl[1] = '{"stuck0",   1, 2, 2, 1, 0};
    tbl[2] = '{"inverted", 2, 8, 0, 1, 0};
    tbl[3] = '{"stuck1",   3, 6, 0, 1, 0};
    tbl[4] = '{"lastrow",  4, 1, 7, 1, 0};

    RESET  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    #3;
    check("rst_vec",  int'(vec0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_err",  int'(err0), 0);
    check("rst_fv",   int'(fv0), 0);
    check("rst_ffi",  int'(ffi0), 0);
    check("rst_busy1", int'(busy1), 0);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;

    // Table-driven sweeps over several DUT behaviours.
    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].mode, -1, -1);
      check_result(tbl[i]);
      prev_pass = tbl[i].exp_pass;
    end

    // start pulses during a running sweep and at the final SAMPLE edge are ignored.
    run_sweep(0, 5, 24);
    check_result(tbl[0]);
    prev_pass = 1;

    // Asynchronous reset mid-SETTLE on row 4.
    y_mode = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("mid_vec", int'(vec0), 4);
    check("mid_busy", int'(busy0), 1);
    #2;
    RESET = 1'b1;
    #1;
    check("arst_vec",  int'(vec0), 0);
    check("arst_busy", int'(busy0), 0);
    check("arst_done", int'(done0), 0);
    check("arst_pass", int'(pass0), 0);
    check("arst_err",  int'(err0), 0);
    check("arst_fv",   int'(fv0), 0);
    check("arst_ffi",  int'(ffi0), 0);
    $display("async reset applied at vec=4");
    @(negedge clk);
    RESET = 1'b0;
    prev_pass = 0;
    run_sweep(0, -1, -1);
    check_result(tbl[0]);

    // SETTLE_CYCLES=1 with start held high: back-to-back sweeps.
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k <= 56; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_done@%0d", k), int'(done1),
            (k == 17 || k == 35 || k == 53) ? 1 : 0);
      check($sformatf("b2b_busy@%0d", k), int'(busy1), ((k % 18) != 17) ? 1 : 0);
      if (done1) begin
        check($sformatf("b2b_pass@%0d", k), int'(pass1), 1);
        check($sformatf("b2b_err@%0d", k), int'(err1), 0);
        $display("b2b sweep done at edge %0d pass=%0d", k, pass1);
      end
    end
    start1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
